// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// uart_rx_pkg : shared state encoding, limits and helpers for the UART receiver
// Revision    : 1.0
// ============================================================================
package uart_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_t;

  localparam int MIN_PRESCALE  = 8;
  localparam int MIN_DATA_BITS = 5;

  // Bit period must be even so the three samples sit symmetrically around P/2.
  function automatic logic [5:0] clean_prescale(input logic [5:0] p);
    logic [5:0] even_p;
    even_p = {p[5:1], 1'b0};
    return (even_p < 6'(MIN_PRESCALE)) ? 6'(MIN_PRESCALE) : even_p;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_receiver_param_if.sv
`default_nettype none
// ============================================================================
// uart_receiver_param_if : serial line, frame configuration and word handshake
// Revision               : 1.0
// ============================================================================
interface uart_receiver_param_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  serial_data_in;
  logic [3:0]            data_bits;
  logic                  parity_enable;
  logic                  parity_type;
  logic                  stop_bits;
  logic [5:0]            prescale;
  logic                  rx_ready;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  parity_error;
  logic                  frame_error;
  logic                  overrun_error;
  logic                  break_detect;
  logic                  busy;

  modport slave (
    input  serial_data_in, data_bits, parity_enable, parity_type, stop_bits,
           prescale, rx_ready,
    output rx_valid, rx_data, parity_error, frame_error, overrun_error,
           break_detect, busy
  );

  modport master (
    output serial_data_in, data_bits, parity_enable, parity_type, stop_bits,
           prescale, rx_ready,
    input  rx_valid, rx_data, parity_error, frame_error, overrun_error,
           break_detect, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_bit_sampler.sv
`default_nettype none
// ============================================================================
// uart_rx_bit_sampler : bit-period counter with 3-sample majority vote
// Revision            : 1.0
// ============================================================================
module uart_rx_bit_sampler
  import uart_rx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       line,
  input  logic [5:0] prescale,
  input  logic       enable,
  output logic       bit_value,
  output logic       bit_done
);

  logic [5:0] r_cnt;
  logic       r_s0;
  logic       r_s1;
  logic [5:0] w_half;

  assign w_half = {1'b0, prescale[5:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_s0  <= 1'b1;
      r_s1  <= 1'b1;
    end else if (!enable) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= (r_cnt == prescale - 6'd1) ? '0 : r_cnt + 6'd1;
      if (r_cnt == w_half - 6'd1) r_s0 <= line;
      if (r_cnt == w_half)        r_s1 <= line;
    end
  end

  // Third sample is the live line value at the decision count.
  assign bit_done  = enable && (r_cnt == w_half + 6'd1);
  assign bit_value = majority3(r_s0, r_s1, line);

endmodule
`default_nettype wire

// File: rtl/uart_receiver_param.sv
`default_nettype none
// ============================================================================
// uart_receiver_param : runtime-configurable UART receiver with error flags
// Revision            : 1.0
// ============================================================================
module uart_receiver_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_receiver_param_if.slave  bus
);

  rx_state_t             r_state;
  logic                  r_sync1, r_sync2, r_prev;
  logic [5:0]            r_prescale;
  logic [3:0]            r_nbits, r_bit_cnt;
  logic                  r_par_en, r_par_type, r_stop2, r_stop_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_acc, r_par_err, r_frm_err, r_all_zero;
  logic                  r_rx_valid, r_perr_out, r_ferr_out, r_overrun, r_break;
  logic [DATA_WIDTH-1:0] r_rx_data;

  logic       w_line, w_start, w_bit, w_done, w_accept, w_enable;
  logic [3:0] w_nbits;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= bus.serial_data_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // r_prev starts low, so a start needs the line seen high first (also after a break).
  assign w_line   = r_sync2;
  assign w_start  = r_prev & ~w_line;
  assign w_accept = r_rx_valid & bus.rx_ready;
  assign w_enable = (r_state != S_IDLE);

  always_comb begin
    w_nbits = bus.data_bits;
    if (bus.data_bits < 4'(MIN_DATA_BITS))
      w_nbits = 4'(MIN_DATA_BITS);
    else if (bus.data_bits > 4'(DATA_WIDTH))
      w_nbits = 4'(DATA_WIDTH);
  end

  uart_rx_bit_sampler u_sampler (
    .clk       (clk),
    .reset     (reset),
    .line      (w_line),
    .prescale  (r_prescale),
    .enable    (w_enable),
    .bit_value (w_bit),
    .bit_done  (w_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_prescale <= 6'(MIN_PRESCALE);
      r_nbits    <= 4'(DATA_WIDTH);
      r_bit_cnt  <= '0;
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_par_acc  <= 1'b0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_all_zero <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_perr_out <= 1'b0;
      r_ferr_out <= 1'b0;
      r_overrun  <= 1'b0;
      r_break    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      r_break   <= 1'b0;
      if (w_accept) r_rx_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_START;
            r_prescale <= clean_prescale(bus.prescale);
            r_nbits    <= w_nbits;
            r_par_en   <= bus.parity_enable;
            r_par_type <= bus.parity_type;
            r_stop2    <= bus.stop_bits;
            r_stop_cnt <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_acc  <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_all_zero <= 1'b1;
          end
        end
        S_START: begin
          if (w_done) r_state <= w_bit ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (w_done) begin
            for (int i = 0; i < DATA_WIDTH; i++)
              if (r_bit_cnt == 4'(i)) r_shift[i] <= w_bit;
            r_par_acc <= r_par_acc ^ w_bit;
            if (w_bit) r_all_zero <= 1'b0;
            if (r_bit_cnt == r_nbits - 4'd1)
              r_state <= r_par_en ? S_PARITY : S_STOP;
            else
              r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
        S_PARITY: begin
          if (w_done) begin
            r_par_err <= ((r_par_acc ^ w_bit) != r_par_type);
            if (w_bit) r_all_zero <= 1'b0;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_done) begin
            if (!r_stop_cnt && r_all_zero && !w_bit) begin
              r_break <= 1'b1;
              r_state <= S_IDLE;
            end else if (r_stop2 && !r_stop_cnt) begin
              r_stop_cnt <= 1'b1;
              r_frm_err  <= r_frm_err | ~w_bit;
            end else begin
              r_state <= S_IDLE;
              // A consumer taking the old word this cycle frees the slot for the new one.
              if (!r_rx_valid || bus.rx_ready) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= r_shift;
                r_perr_out <= r_par_err;
                r_ferr_out <= r_frm_err | ~w_bit;
              end else begin
                r_overrun <= 1'b1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_valid      = r_rx_valid;
  assign bus.rx_data       = r_rx_data;
  assign bus.parity_error  = r_perr_out;
  assign bus.frame_error   = r_ferr_out;
  assign bus.overrun_error = r_overrun;
  assign bus.break_detect  = r_break;
  assign bus.busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_receiver_param.md
UART_RECEIVER_PARAM -- requirements
Module: uart_receiver_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, maximum data bits per frame (legal 5..9).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port serial_data_in  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port data_bits  input  4  runtime data-bit count.
REQ-006 SHALL have port parity_enable  input  1  1 = parity bit present.
REQ-007 SHALL have port parity_type  input  1  0 = even, 1 = odd.
REQ-008 SHALL have port stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
REQ-009 SHALL have port prescale  input  6  clk cycles per bit.
REQ-010 SHALL have port rx_ready  input  1  consumer accepts the word.
REQ-011 SHALL have port rx_valid  output  1  word held on rx_data.
REQ-012 SHALL have port rx_data  output  DATA_WIDTH  received word, LSB first on line; bits above data_bits read 0.
REQ-013 SHALL have port parity_error  output  1  parity flag of held word.
REQ-014 SHALL have port frame_error  output  1  stop-bit flag of held word.
REQ-015 SHALL have port overrun_error  output  1  one-cycle pulse: completed frame dropped.
REQ-016 SHALL have port break_detect  output  1  one-cycle pulse: break frame received.
REQ-017 SHALL have port busy  output  1  high from START through STOP.

Function
REQ-018 SHALL pass serial_data_in through a 2-flop synchroniser (reset to 1) before all use.
REQ-019 SHALL, in IDLE, detect a start on a 1->0 transition of the synchronised line and latch data_bits, parity_enable, parity_type, stop_bits and prescale for the whole frame.
REQ-020 SHALL force prescale[0] to 0 and raise values below 8 to 8; SHALL clamp data_bits into 5..DATA_WIDTH.
REQ-021 SHALL count each bit period 0..P-1 and take three samples at counts P/2-1, P/2, P/2+1, the bit value being the 2-of-3 majority decided at count P/2+1.
REQ-022 SHALL use states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when parity_enable=0.
REQ-023 SHALL return from START to IDLE with no output when the start-bit majority is 1 (glitch rejection).
REQ-024 SHALL shift data LSB first, leaving DATA after data_bits bits.
REQ-025 SHALL flag parity error when XOR(data bits, parity bit) differs from parity_type.
REQ-026 SHALL flag frame error when any stop-bit majority is 0.
REQ-027 SHALL go STOP->IDLE at the decision point of the last stop bit, allowing a next start edge within the remaining half bit.
REQ-028 SHALL set rx_valid the cycle after that decision and hold rx_data, parity_error, frame_error stable until rx_valid && rx_ready.
REQ-029 SHALL, when a frame completes while rx_valid=1 and rx_ready=0, keep the old word and pulse overrun_error; when rx_ready=1 in that same cycle, SHALL load the new word with no overrun.
REQ-030 SHALL, when all data bits, the parity bit (if enabled) and the first stop bit are 0, pulse break_detect, not assert rx_valid, and wait in IDLE until the line returns to 1.

Reset
REQ-031 SHALL, on reset low, immediately enter IDLE and drive rx_valid, rx_data, parity_error, frame_error, overrun_error, break_detect, busy to 0; an in-progress frame is discarded.
REQ-032 SHALL resume start detection only after the synchronised line has been high for one clk following reset release.

Structure
REQ-033 SHALL place the state enumeration and constants MIN_PRESCALE=8, MIN_DATA_BITS=5 in package uart_rx_pkg.
REQ-034 SHALL implement bit timing and majority vote in sub-module uart_rx_bit_sampler (inputs line, prescale, enable; outputs bit_value, bit_done).

Verification
REQ-035 SHALL cover: prescale=16, 8N1, byte 0xA5, rx_ready=1 -> rx_valid one clk after stop decision, rx_data=0xA5, no errors.
REQ-036 SHALL cover: 7E2, data 0x41 sent with wrong parity bit -> rx_data=0x41, parity_error=1, frame_error=0.
REQ-037 SHALL cover: 4-clk low glitch, prescale=16 -> no rx_valid, busy returns to 0 by count 10.
REQ-038 SHALL cover: two frames 0x11, 0x22 with rx_ready=0 -> rx_data stays 0x11, one overrun_error pulse.
REQ-039 SHALL cover: line low for 12 bit times, 8N1 -> one break_detect pulse, rx_valid=0, next frame 0x5A received correctly.
REQ-040 SHALL cover: reset asserted mid DATA -> outputs 0 asynchronously, next frame 0x3C received error-free.
